// File: rtl/register_bus_arbiter.sv
// Register bus arbiter: round-robin arbitration between a host bridge (A)
// and an internal copier (B) for one register-file bus. Each transaction runs
// IDLE -> SETUP -> STROBE (STROBE_CYCLES clocks) -> HOLD. Every output is a flop.
// STROBE_CYCLES must be 1 or more.
module register_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [1:0]            a_be,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [1:0]            b_be,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  reg_en,
    output logic                  reg_rd_n,
    output logic                  reg_wr_n,
    output logic [1:0]            reg_be,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy
);

    localparam int unsigned BE_W  = 2;
    localparam int unsigned CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // last_grant_q: 0 = A, 1 = B; also identifies the owner of the current transaction
    logic last_grant_q, last_grant_d;
    logic wr_q, wr_d;
    logic grant_a_c, grant_b_c;

    logic                  reg_en_q, reg_en_d;
    logic                  reg_rd_n_q, reg_rd_n_d;
    logic                  reg_wr_n_q, reg_wr_n_d;
    logic [BE_W-1:0]       reg_be_q, reg_be_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic                  busy_q, busy_d;

    // State register plus all registered outputs and datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            reg_en_q     <= 1'b0;
            reg_rd_n_q   <= 1'b1;
            reg_wr_n_q   <= 1'b1;
            reg_be_q     <= '0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            reg_en_q     <= reg_en_d;
            reg_rd_n_q   <= reg_rd_n_d;
            reg_wr_n_q   <= reg_wr_n_d;
            reg_be_q     <= reg_be_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: round-robin grant in IDLE, strobe down-counter in STROBE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (a_req && (!b_req || last_grant_q)) begin
                    grant_a_c = 1'b1;
                end else if (b_req) begin
                    grant_b_c = 1'b1;
                end
                if (grant_a_c || grant_b_c) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = CNT_W'(STROBE_CYCLES - 1);
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the output flops, derived from the upcoming state
    always_comb begin
        reg_en_d     = 1'b0;
        reg_rd_n_d   = 1'b1;
        reg_wr_n_d   = 1'b1;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        busy_d       = (state_d != S_IDLE);
        reg_be_d     = reg_be_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        wr_d         = wr_q;
        last_grant_d = last_grant_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        if (grant_a_c) begin
            wr_d         = a_wr;
            reg_be_d     = a_be;
            reg_addr_d   = a_addr;
            reg_wdata_d  = a_wdata;
            last_grant_d = 1'b0;
        end else if (grant_b_c) begin
            wr_d         = b_wr;
            reg_be_d     = b_be;
            reg_addr_d   = b_addr;
            reg_wdata_d  = b_wdata;
            last_grant_d = 1'b1;
        end

        unique case (state_d)
            S_SETUP: begin
                reg_en_d = 1'b1;
            end
            S_STROBE: begin
                reg_en_d   = 1'b1;
                reg_rd_n_d = wr_q;
                reg_wr_n_d = ~wr_q;
            end
            S_HOLD: begin
                reg_en_d = 1'b1;
                a_ack_d  = ~last_grant_q;
                b_ack_d  = last_grant_q;
            end
            default: begin
            end
        endcase

        // Read data is captured on the edge that ends the last strobe cycle
        if ((state_q == S_STROBE) && (state_d == S_HOLD) && !wr_q) begin
            if (last_grant_q) begin
                b_rdata_d = reg_rdata;
            end else begin
                a_rdata_d = reg_rdata;
            end
        end
    end

    assign reg_en    = reg_en_q;
    assign reg_rd_n  = reg_rd_n_q;
    assign reg_wr_n  = reg_wr_n_q;
    assign reg_be    = reg_be_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_register_bus_arbiter.sv
// Bench for register_bus_arbiter: scoreboard of expected acks checked by a
// negedge monitor, plus a STROBE_CYCLES=1 instance checked cycle by cycle.
module tb_register_bus_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance u0: default STROBE_CYCLES=2
    logic a_req, b_req, a_wr, b_wr;
    logic [1:0] a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic reg_en, reg_rd_n, reg_wr_n, busy;
    logic [1:0] reg_be;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata, reg_rdata;

    // Instance u1: STROBE_CYCLES=1
    logic s_a_req, s_b_req, s_a_wr, s_b_wr;
    logic [1:0] s_a_be, s_b_be;
    logic [AW-1:0] s_a_addr, s_b_addr;
    logic [DW-1:0] s_a_wdata, s_b_wdata;
    logic s_a_ack, s_b_ack;
    logic [DW-1:0] s_a_rdata, s_b_rdata;
    logic s_reg_en, s_reg_rd_n, s_reg_wr_n, s_busy;
    logic [1:0] s_reg_be;
    logic [AW-1:0] s_reg_addr;
    logic [DW-1:0] s_reg_wdata, s_reg_rdata;

    register_bus_arbiter u0 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .reg_en(reg_en), .reg_rd_n(reg_rd_n), .reg_wr_n(reg_wr_n), .reg_be(reg_be),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy)
    );

    register_bus_arbiter #(.STROBE_CYCLES(1)) u1 (
        .clk(clk), .reset(reset),
        .a_req(s_a_req), .a_wr(s_a_wr), .a_be(s_a_be), .a_addr(s_a_addr), .a_wdata(s_a_wdata),
        .a_ack(s_a_ack), .a_rdata(s_a_rdata),
        .b_req(s_b_req), .b_wr(s_b_wr), .b_be(s_b_be), .b_addr(s_b_addr), .b_wdata(s_b_wdata),
        .b_ack(s_b_ack), .b_rdata(s_b_rdata),
        .reg_en(s_reg_en), .reg_rd_n(s_reg_rd_n), .reg_wr_n(s_reg_wr_n), .reg_be(s_reg_be),
        .reg_addr(s_reg_addr), .reg_wdata(s_reg_wdata), .reg_rdata(s_reg_rdata), .busy(s_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    int wr_low_total = 0;
    int wr_low_last  = -1;

    // Register file model for u0: latches on the rising edge of reg_wr_n
    logic [DW-1:0] mem [0:31];
    always @(posedge reg_wr_n) begin
        if (reg_en === 1'b1) begin
            if (reg_be[0]) mem[reg_addr][7:0]  <= reg_wdata[7:0];
            if (reg_be[1]) mem[reg_addr][15:8] <= reg_wdata[15:8];
        end
    end
    assign reg_rdata = mem[reg_addr];

    typedef struct {
        bit            is_b;
        int            cyc;
        logic [DW-1:0] a_rd;
        logic [DW-1:0] b_rd;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input bit is_b, input int c, input logic [DW-1:0] ar,
                                 input logic [DW-1:0] br);
        exp_t e;
        e.is_b = is_b;
        e.cyc  = c;
        e.a_rd = ar;
        e.b_rd = br;
        exp_q.push_back(e);
    endfunction

    // Requester model: hold req until ack, drop it the cycle after, return one cycle later
    task automatic req_txn(input bit is_b, input bit wr, input logic [1:0] be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bit seen;
        seen = 1'b0;
        if (!is_b) begin
            a_wr = wr; a_be = be; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        end else begin
            b_wr = wr; b_be = be; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = is_b ? (b_ack === 1'b1) : (a_ack === 1'b1);
        end
        chk(is_b ? "b_ack_seen" : "a_ack_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        if (!is_b) a_req = 1'b0; else b_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: bus invariants every cycle, scoreboard pop on every ack
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("strobes_both_low", 32'(reg_rd_n === 1'b0 && reg_wr_n === 1'b0), 32'd0);
            chk("acks_both_high", 32'(a_ack === 1'b1 && b_ack === 1'b1), 32'd0);
            if (busy === 1'b0) chk("idle_bus", 32'({reg_en, reg_rd_n, reg_wr_n}), 32'b011);
            if (reg_wr_n === 1'b0) begin
                wr_low_total++;
                wr_low_last = cyc;
            end
            if (a_ack === 1'b1 || b_ack === 1'b1) begin
                chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ack_is_b", 32'(b_ack), 32'(e.is_b));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("a_rdata", 32'(a_rdata), 32'(e.a_rd));
                    chk("b_rdata", 32'(b_rdata), 32'(e.b_rd));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, w0, low;
        reset = 1'b1;
        a_req = 0; b_req = 0; a_wr = 0; b_wr = 0; a_be = 0; b_be = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        s_a_req = 0; s_b_req = 0; s_a_wr = 0; s_b_wr = 0; s_a_be = 0; s_b_be = 0;
        s_a_addr = 0; s_b_addr = 0; s_a_wdata = 0; s_b_wdata = 0; s_reg_rdata = 0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_reg_en", 32'(reg_en), 32'd0);
        chk("rst_reg_rd_n", 32'(reg_rd_n), 32'd1);
        chk("rst_reg_wr_n", 32'(reg_wr_n), 32'd1);
        chk("rst_reg_be", 32'(reg_be), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_a_ack", 32'(a_ack), 32'd0);
        chk("rst_b_ack", 32'(b_ack), 32'd0);
        chk("rst_a_rdata", 32'(a_rdata), 32'd0);
        chk("rst_b_rdata", 32'(b_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Both requesting from reset: A, B, A, B with 5-cycle ack spacing
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;
        c = cyc;
        push(1'b0, c + 4,  16'h0000, 16'h0000);
        push(1'b1, c + 9,  16'h0000, 16'h0000);
        push(1'b0, c + 14, 16'h5555, 16'h0000);
        push(1'b1, c + 19, 16'h5555, 16'hC0DE);
        fork
            begin
                req_txn(1'b0, 1'b1, 2'b11, 5'd0, 16'hC0DE);
                req_txn(1'b0, 1'b0, 2'b11, 5'd1, 16'h0000);
            end
            begin
                req_txn(1'b1, 1'b1, 2'b11, 5'd1, 16'h5555);
                req_txn(1'b1, 1'b0, 2'b11, 5'd0, 16'h0000);
            end
        join

        // A write addr 3: strobe low in cycles 2-3, ack in cycle 4
        c  = cyc;
        w0 = wr_low_total;
        push(1'b0, c + 4, 16'h5555, 16'hC0DE);
        req_txn(1'b0, 1'b1, 2'b11, 5'd3, 16'h1234);
        chk("wr_low_count", 32'(wr_low_total - w0), 32'd2);
        chk("wr_low_last", 32'(wr_low_last), 32'(c + 3));
        chk("mem3_write", 32'(mem[3]), 32'h1234);

        // B arrives during A's strobe and is granted right after A's HOLD
        c = cyc;
        push(1'b0, c + 4, 16'h1234, 16'hC0DE);
        push(1'b1, c + 9, 16'h1234, 16'hC0DE);
        fork
            req_txn(1'b0, 1'b0, 2'b11, 5'd3, 16'h0000);
            begin
                repeat (2) @(posedge clk);
                #1;
                req_txn(1'b1, 1'b1, 2'b10, 5'd3, 16'hBEEF);
            end
        join
        chk("mem3_high_byte", 32'(mem[3]), 32'hBE34);

        // B read leaves a_rdata untouched
        c = cyc;
        push(1'b1, c + 4, 16'h1234, 16'hBE34);
        req_txn(1'b1, 1'b0, 2'b11, 5'd3, 16'h0000);

        // Reset in the second strobe cycle of a write aborts it with no ack
        c  = cyc;
        w0 = wr_low_total;
        a_wr = 1'b1; a_be = 2'b11; a_addr = 5'd7; a_wdata = 16'h7777; a_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        a_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_wr_n", 32'(reg_wr_n), 32'd1);
        chk("abort_reg_en", 32'(reg_en), 32'd0);
        chk("abort_a_ack", 32'(a_ack), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_a_rdata", 32'(a_rdata), 32'd0);
        chk("abort_wr_low_count", 32'(wr_low_total - w0), 32'd2);
        chk("abort_cycle", 32'(cyc), 32'(c + 4));
        repeat (6) @(posedge clk);
        #1;

        // After reset last_grant is B, so A wins a simultaneous request
        c = cyc;
        push(1'b0, c + 4, 16'h0000, 16'h0000);
        push(1'b1, c + 9, 16'h0000, 16'hBE34);
        fork
            req_txn(1'b0, 1'b1, 2'b11, 5'd8, 16'h1111);
            req_txn(1'b1, 1'b0, 2'b11, 5'd3, 16'h0000);
        join

        // STROBE_CYCLES=1 instance: be=01 held, single strobe cycle, ack in cycle 3
        c   = cyc;
        low = 0;
        s_a_wr = 1'b1; s_a_be = 2'b01; s_a_addr = 5'd5; s_a_wdata = 16'hABCD; s_a_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (s_reg_wr_n === 1'b0) low++;
            case (k)
                0: chk("s1_c0_busy", 32'(s_busy), 32'd0);
                1: begin
                    chk("s1_c1_en", 32'({s_reg_en, s_reg_wr_n}), 32'b11);
                    chk("s1_c1_be", 32'(s_reg_be), 32'b01);
                end
                2: begin
                    chk("s1_c2_wr_n", 32'(s_reg_wr_n), 32'd0);
                    chk("s1_c2_be", 32'(s_reg_be), 32'b01);
                    chk("s1_c2_addr", 32'(s_reg_addr), 32'd5);
                    chk("s1_c2_wdata", 32'(s_reg_wdata), 32'hABCD);
                end
                3: begin
                    chk("s1_c3_ack", 32'(s_a_ack), 32'd1);
                    chk("s1_c3_wr_n", 32'(s_reg_wr_n), 32'd1);
                    chk("s1_c3_be", 32'(s_reg_be), 32'b01);
                    @(posedge clk); #1;
                    s_a_req = 1'b0;
                end
                default: begin
                    chk("s1_c4_ack", 32'(s_a_ack), 32'd0);
                    chk("s1_c4_en", 32'(s_reg_en), 32'd0);
                end
            endcase
        end
        chk("s1_strobe_low_cycles", 32'(low), 32'd1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_bus_arbiter.md
REGISTER_BUS_ARBITER -- requirements
Module: register_bus_arbiter

Interface
REQ-001 The parameter ADDR_WIDTH SHALL default to 5 and set the register address width.
REQ-002 The parameter DATA_WIDTH SHALL default to 16 and set the register data width.
REQ-003 The parameter STROBE_CYCLES SHALL default to 2, set the strobe-low duration in clocks, and be legal only for values of 1 or more.
REQ-004 clk  input  1  system clock; one clock domain, all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 a_req, b_req  input  1  per-requester transaction request; A = host bridge, B = internal copier.
REQ-007 a_wr, b_wr  input  1  1 = write, 0 = read.
REQ-008 a_be, b_be  input  2  byte enables; bit 0 = low byte, bit 1 = high byte.
REQ-009 a_addr, b_addr  input  ADDR_WIDTH  register address.
REQ-010 a_wdata, b_wdata  input  DATA_WIDTH  write data.
REQ-011 a_ack, b_ack  output  1  one-cycle completion pulse.
REQ-012 a_rdata, b_rdata  output  DATA_WIDTH  read data; held until that requester's next read completes.
REQ-013 reg_en  output  1  register file access enable.
REQ-014 reg_rd_n, reg_wr_n  output  1  active-low read and write strobes; the register file latches on the reg_wr_n rising edge.
REQ-015 reg_be, reg_addr, reg_wdata  output  2 / ADDR_WIDTH / DATA_WIDTH  bus byte enables, address and write data.
REQ-016 reg_rdata  input  DATA_WIDTH  register file read data.
REQ-017 busy  output  1  high in every state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD, and every output SHALL be registered.
REQ-019 In IDLE with exactly one req high, the block SHALL grant that requester; with both high it SHALL grant the requester not in last_grant (round-robin).
REQ-020 On a grant, the block SHALL latch wr/be/addr/wdata into the bus registers, update last_grant, and enter SETUP.
REQ-021 In SETUP (1 cycle), the block SHALL drive reg_en=1, reg_rd_n=1, reg_wr_n=1, with address, data and byte enables stable.
REQ-022 In STROBE (STROBE_CYCLES cycles, counted by an internal down-counter), the block SHALL drive reg_rd_n=0 for a read or reg_wr_n=0 for a write, with reg_en=1.
REQ-023 In HOLD (1 cycle), both strobes SHALL be high, reg_en and the bus SHALL be held, and the granted requester's ack SHALL be high; the next state is IDLE.
REQ-024 A read SHALL capture reg_rdata into the granted requester's rdata at the clock edge ending the last STROBE cycle, so the data is valid when ack is high.
REQ-025 A write SHALL leave both rdata outputs unchanged.
REQ-026 Latency: with req first sampled in IDLE at cycle 0, ack SHALL be high in cycle 2+STROBE_CYCLES (cycle 4 at the default).
REQ-027 Throughput: every transaction SHALL pass through at least one IDLE cycle, giving a minimum of 3+STROBE_CYCLES cycles per transaction.
REQ-028 Handshake: a requester SHALL hold req and its fields stable until ack, and SHALL drop req in the cycle after ack; a req still high in that cycle SHALL be treated as a new request.
REQ-029 A granted transaction SHALL complete even if its req drops mid-transaction.
REQ-030 A request from the non-granted requester that arrives during a transaction SHALL wait, not be lost, and be granted at the next IDLE.
REQ-031 In IDLE, reg_en SHALL be 0 and both strobes SHALL be 1.
REQ-032 The block SHALL never drive reg_rd_n and reg_wr_n low together.
REQ-033 The block SHALL never assert a_ack and b_ack together.

Reset
REQ-034 When reset is sampled high, the block SHALL on that edge set: state=IDLE, reg_en=0, reg_rd_n=1, reg_wr_n=1, reg_be=0, reg_addr=0, reg_wdata=0, a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, last_grant=B.
REQ-035 A reset during STROBE SHALL abort the transaction, return both strobes high on that edge, and produce no ack.

Verification
REQ-036 Scenario: A write, addr=3, wdata=0x1234, be=2'b11 -> reg_wr_n low in cycles 2-3, a_ack in cycle 4, and a 0x1234 write lands on the reg_wr_n rising edge.
REQ-037 Scenario: B read, addr=0, reg_rdata=0xC0DE -> b_rdata=0xC0DE with b_ack in cycle 4, and a_rdata unchanged.
REQ-038 Scenario: a_req and b_req both high from reset -> grants go A, B, A, B in turn, with 5-cycle spacing between acks.
REQ-039 Scenario: b_req rises during A's STROBE -> B is granted in the IDLE cycle right after A's HOLD, and no request is dropped.
REQ-040 Scenario: reset asserted in the second STROBE cycle of a write -> reg_wr_n=1 and reg_en=0 on the next edge, with no ack.
REQ-041 Scenario: STROBE_CYCLES=1 with be=2'b01 -> reg_be=01 throughout the transaction, ack in cycle 3, and the strobe is low for exactly one cycle.
